// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, FSM encodings and one-hot state bit positions for the
// run/stop sequencer and the instruction decoder that consumes its state vector.
package control_sequencer_pkg;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_JMP = 4'd3;
  localparam logic [3:0] OP_STP = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_JMS = 4'd6;
  localparam logic [3:0] OP_BBL = 4'd7;

  // Any opcode with this bit set is an ARM coprocessor operation.
  localparam int ARM_BIT = 3;

  // Bit positions in the one-hot state vector seen by the decoder.
  localparam int ST_FETCH_BIT = 0;
  localparam int ST_EXEC1_BIT = 1;
  localparam int ST_EXEC2_BIT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } fsm_state_t;

  // Decoder-facing one-hot vector; all zero in IDLE, HALT and FAULT.
  function automatic logic [2:0] onehot_state(input fsm_state_t s);
    logic [2:0] v;
    v = '0;
    case (s)
      S_FETCH: v[ST_FETCH_BIT] = 1'b1;
      S_EXEC1: v[ST_EXEC1_BIT] = 1'b1;
      S_EXEC2: v[ST_EXEC2_BIT] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the CPU datapath (master) and the sequencer (slave).
//
// Handshake: arm_req/arm_done is a request/acknowledge pair. arm_req is high in
// EXEC1 of an ARM op while arm_done is low; the sequencer samples arm_done on
// every EXEC1 clock edge and moves to FETCH on the first edge that sees it high.
// arm_done already high on the first EXEC1 cycle completes the op with no
// arm_req pulse. go is a level sampled only in IDLE and HALT.
interface control_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 3
);
  import control_sequencer_pkg::*;

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               go;
  logic [3:0]         inst;
  logic [ADDR_W-1:0]  pc_in;
  logic               arm_done;

  logic [2:0]         state;
  logic               ir_load;
  logic               arm_req;
  logic               ret_load;
  logic [ADDR_W-1:0]  ret_addr;
  logic               halted;
  logic               fault;
  logic [DEPTH_W-1:0] depth;
  fsm_state_t         dbg_state;

  modport master (
    output go, inst, pc_in, arm_done,
    input  state, ir_load, arm_req, ret_load, ret_addr, halted, fault, depth,
           dbg_state
  );

  modport slave (
    input  go, inst, pc_in, arm_done,
    output state, ir_load, arm_req, ret_load, ret_addr, halted, fault, depth,
           dbg_state
  );

endinterface

// File: rtl/control_sequencer_return_stack.sv
// Subroutine return-address LIFO. No wrap: a push when full or a pop when empty
// is ignored here; the sequencer turns those cases into a FAULT instead.
// Popped entries are left in place, only the occupancy count moves.
module control_sequencer_return_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 3,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  din,
  output logic [ADDR_W-1:0]  top,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);

  logic [ADDR_W-1:0]  mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] cnt;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   top_idx;

  assign full    = (cnt == DEPTH_W'(STACK_DEPTH));
  assign empty   = (cnt == '0);
  assign depth   = cnt;
  assign wr_idx  = IDX_W'(cnt);
  assign top_idx = IDX_W'(cnt - 1'b1);
  assign top     = empty ? '0 : mem[top_idx];

  // Occupancy counter and storage; reset empties the stack immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      cnt         <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Run/stop sequencer: walks FETCH/EXEC1/EXEC2 for each instruction, owns the
// JMS/BBL return stack and stretches EXEC1 while an ARM op waits for arm_done.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.slave  bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  fsm_state_t         cur, nxt;
  logic               push, pop;
  logic               stk_full, stk_empty;
  logic [ADDR_W-1:0]  stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               ir_load, arm_req, ret_load;

  control_sequencer_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc_in + ADDR_W'(1)),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (stk_depth)
  );

  // State register; async reset returns to IDLE and so drops arm_req at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    nxt      = cur;
    ir_load  = 1'b0;
    arm_req  = 1'b0;
    ret_load = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (cur)
      S_IDLE:  if (bus.go) nxt = S_FETCH;
      S_FETCH: begin
        ir_load = 1'b1;
        nxt     = S_EXEC1;
      end
      S_EXEC1: begin
        if (bus.inst[ARM_BIT]) begin
          // Hold EXEC1 until the coprocessor acknowledges.
          if (bus.arm_done) nxt = S_FETCH;
          else              arm_req = 1'b1;
        end else begin
          case (bus.inst)
            OP_STP:         nxt = S_HALT;
            OP_LDA, OP_ADD: nxt = S_EXEC2;
            OP_JMS: begin
              if (stk_full) nxt = S_FAULT;
              else begin
                push = 1'b1;
                nxt  = S_EXEC2;
              end
            end
            OP_BBL: begin
              if (stk_empty) nxt = S_FAULT;
              else begin
                ret_load = 1'b1;
                pop      = 1'b1;
                nxt      = S_FETCH;
              end
            end
            default:        nxt = S_FETCH;
          endcase
        end
      end
      S_EXEC2: nxt = S_FETCH;
      S_HALT:  if (bus.go) nxt = S_FETCH;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  assign bus.state     = onehot_state(cur);
  assign bus.ir_load   = ir_load;
  assign bus.arm_req   = arm_req;
  assign bus.ret_load  = ret_load;
  assign bus.ret_addr  = ret_load ? stk_top : '0;
  assign bus.halted    = (cur == S_HALT) || (cur == S_FAULT);
  assign bus.fault     = (cur == S_FAULT);
  assign bus.depth     = stk_depth;
  assign bus.dbg_state = cur;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios followed by random instruction
// streams; a per-instruction reference model pushes expected output snapshots.
module tb_control_sequencer;

  localparam int ADDR_W      = 8;
  localparam int STACK_DEPTH = 3;
  localparam int SW          = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  control_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) sif ();

  control_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard storage
  logic [SW-1:0] exp_q[$];
  string         lbl_q[$];
  int            tests = 0;
  int            fails = 0;

  // Reference model: run mode plus the return stack as a plain queue
  typedef enum int {M_IDLE, M_RUN, M_HALT, M_FAULT} mode_t;
  mode_t      mode = M_IDLE;
  logic [7:0] mstack[$];

  // Snapshot: {state, ir_load, arm_req, ret_load, ret_addr, halted, fault, depth}
  function automatic logic [SW-1:0] snap(input logic [2:0] st, input logic irl,
                                         input logic arq, input logic rl,
                                         input logic [7:0] ra, input logic hl,
                                         input logic flt, input logic [1:0] dp);
    return {st, irl, arq, rl, ra, hl, flt, dp};
  endfunction

  function logic [1:0] mdepth();
    return 2'(mstack.size());
  endfunction

  function logic [SW-1:0] quiet(input logic [2:0] st);
    return snap(st, 1'b0, 1'b0, 1'b0, 8'h00,
                (mode == M_HALT) || (mode == M_FAULT), mode == M_FAULT, mdepth());
  endfunction

  // Driver: one clock cycle of inputs plus the outputs expected during it
  task automatic cyc(input logic g, input logic [3:0] in, input logic [7:0] pc,
                     input logic ad, input logic [SW-1:0] e, input string lbl);
    @(posedge clk);
    #1;
    sif.go       = g;
    sif.inst     = in;
    sif.pc_in    = pc;
    sif.arm_done = ad;
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
  endtask

  // A cycle spent in IDLE, HALT or FAULT
  task automatic idle_cycle(input logic g);
    cyc(g, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
        1'($urandom_range(0, 1)), quiet(3'b000), "idle");
    if (g && (mode == M_IDLE || mode == M_HALT)) mode = M_RUN;
  endtask

  // One instruction starting in FETCH; the model decides its cycle trace
  task automatic exec_instr(input logic [3:0] in, input logic [7:0] pc, input int nwait);
    logic g;
    g = 1'($urandom_range(0, 1));
    cyc(g, in, pc, 1'($urandom_range(0, 1)),
        snap(3'b001, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mdepth()), "fetch");
    if (in[3]) begin
      for (int i = 0; i < nwait; i++)
        cyc(g, in, pc, 1'b0, snap(3'b010, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mdepth()),
            "arm_wait");
      cyc(g, in, pc, 1'b1, quiet(3'b010), "arm_done");
    end else begin
      case (in)
        4'd4: begin
          cyc(g, in, pc, 1'b0, quiet(3'b010), "stp");
          mode = M_HALT;
        end
        4'd2, 4'd5: begin
          cyc(g, in, pc, 1'b0, quiet(3'b010), "exec1_long");
          cyc(g, in, pc, 1'b0, quiet(3'b100), "exec2");
        end
        4'd6: begin
          cyc(g, in, pc, 1'b0, quiet(3'b010), "jms");
          if (mstack.size() == STACK_DEPTH) mode = M_FAULT;
          else begin
            mstack.push_back(pc + 8'd1);
            cyc(g, in, pc, 1'b0, quiet(3'b100), "jms_exec2");
          end
        end
        4'd7: begin
          if (mstack.size() == 0) begin
            cyc(g, in, pc, 1'b0, quiet(3'b010), "bbl_empty");
            mode = M_FAULT;
          end else begin
            cyc(g, in, pc, 1'b0,
                snap(3'b010, 1'b0, 1'b0, 1'b1, mstack[$], 1'b0, 1'b0, mdepth()), "bbl");
            void'(mstack.pop_back());
          end
        end
        default: cyc(g, in, pc, 1'b0, quiet(3'b010), "exec1_short");
      endcase
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    mstack.delete();
  endtask

  // Synchronous-looking reset pulse with checks during and after
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(quiet(3'b000));
    lbl_q.push_back("reset");
    cyc(1'b0, 4'd0, 8'h00, 1'b0, quiet(3'b000), "reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(quiet(3'b000));
    lbl_q.push_back("reset_release");
  endtask

  // ARM op interrupted by reset mid-cycle: outputs must clear before the next edge
  task automatic arm_reset();
    cyc(1'b0, 4'b1010, 8'h33, 1'b0,
        snap(3'b001, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mdepth()), "fetch");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 4'b1010, 8'h33, 1'b0,
          snap(3'b010, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mdepth()), "arm_wait");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(quiet(3'b000));
    lbl_q.push_back("async_reset");
    cyc(1'b0, 4'b1010, 8'h33, 1'b0, quiet(3'b000), "reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(quiet(3'b000));
    lbl_q.push_back("idle_after_release");
  endtask

  // Monitor: compare whatever the DUT presents against the next expected entry
  logic [SW-1:0] mon_got, mon_exp;
  string         mon_lbl;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_lbl = lbl_q.pop_front();
      mon_got = {sif.state, sif.ir_load, sif.arm_req, sif.ret_load, sif.ret_addr,
                 sif.halted, sif.fault, sif.depth};
      tests++;
      if (mon_got !== mon_exp) begin
        fails++;
        $display("FAIL %s @%0t: got {st,ir,arq,rl,ra,h,f,d}=%b required %b",
                 mon_lbl, $time, mon_got, mon_exp);
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    logic [3:0] in;
    sif.go = 1'b0; sif.inst = 4'd0; sif.pc_in = 8'h00; sif.arm_done = 1'b0;

    @(posedge clk);
    #1;
    exp_q.push_back(quiet(3'b000));
    lbl_q.push_back("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(quiet(3'b000));
    lbl_q.push_back("idle_after_reset");

    // Start-up and basic instruction shapes
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    exec_instr(4'd0, 8'h00, 0);
    exec_instr(4'd2, 8'h01, 0);
    exec_instr(4'd4, 8'h02, 0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    exec_instr(4'd0, 8'h03, 0);

    // Subroutine call/return, including return-address wrap
    exec_instr(4'd6, 8'h10, 0);
    exec_instr(4'd7, 8'h20, 0);
    exec_instr(4'd6, 8'hff, 0);
    exec_instr(4'd7, 8'h40, 0);

    // Overflow on the fourth nested call, go ignored in FAULT
    for (int i = 0; i < 4; i++) exec_instr(4'd6, 8'(8'h50 + i), 0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    apply_reset();

    // Underflow straight after reset
    idle_cycle(1'b1);
    exec_instr(4'd7, 8'h60, 0);
    idle_cycle(1'b1);
    apply_reset();

    // ARM wait stretch and immediate completion
    idle_cycle(1'b1);
    exec_instr(4'b1000, 8'h70, 5);
    exec_instr(4'b1000, 8'h71, 0);

    // Reset during an ARM wait with two return addresses stacked
    exec_instr(4'd6, 8'h80, 0);
    exec_instr(4'd6, 8'h90, 0);
    arm_reset();
    idle_cycle(1'b0);

    // Random instruction streams
    for (int n = 0; n < 400; n++) begin
      case (mode)
        M_RUN: begin
          r  = int'($urandom_range(0, 9));
          in = (r < 8) ? 4'(r) : {1'b1, 3'($urandom_range(0, 7))};
          exec_instr(in, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end
        M_FAULT: begin
          idle_cycle(1'b1);
          apply_reset();
        end
        default: idle_cycle(1'($urandom_range(0, 1)));
      endcase
    end

    // Drain the scoreboard
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
